// File: rtl/clk_halt_if.sv
// Halt-controller signal bundle: core-side requests and wake sources in,
// clock-gating controls and status out.
interface clk_halt_if #(
    parameter int CNT_W = 16
);
    logic             halt_req;
    logic             pipe_empty;
    logic             intr;
    logic             intr_en;
    logic             nmi;
    logic             dbg_resume;
    logic             stop;
    logic             resume_n;
    logic             halted;
    logic             drain_to;
    logic [CNT_W-1:0] stop_cnt;

    modport master (
        output halt_req, pipe_empty, intr, intr_en, nmi, dbg_resume,
        input  stop, resume_n, halted, drain_to, stop_cnt
    );

    modport slave (
        input  halt_req, pipe_empty, intr, intr_en, nmi, dbg_resume,
        output stop, resume_n, halted, drain_to, stop_cnt
    );
endinterface

// File: rtl/clk_halt_ctrl.sv
// HLT power-down sequencer: drains the pipe, stops the gated core clock, and
// pulses resume_n on wake. Runs on the free-running clock.
module clk_halt_ctrl #(
    parameter int DRAIN_MAX  = 16,
    parameter int RESUME_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    clk_halt_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, STOPPED, WAKE} state_t;

    state_t     state, nstate;
    logic [7:0] drain_cnt;
    logic [3:0] res_cnt;
    logic       wake;
    logic       halt_ok;
    logic       drain_tmo;
    logic       stop_d, resume_n_d, halted_d;

    assign wake      = bus.nmi | (bus.intr & bus.intr_en) | bus.dbg_resume;
    assign halt_ok   = (state == RUN) & bus.halt_req & ~wake;
    // Timeout only counts when neither wake nor an empty pipe resolved the drain first.
    assign drain_tmo = (state == DRAIN) & ~wake & ~bus.pipe_empty
                       & (drain_cnt == 8'(DRAIN_MAX - 1));

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            res_cnt   <= '0;
        end else begin
            state <= nstate;
            if (state == DRAIN) drain_cnt <= drain_cnt + 8'd1;
            else                drain_cnt <= '0;
            if (state == WAKE)  res_cnt   <= res_cnt + 4'd1;
            else                res_cnt   <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        unique case (state)
            RUN:     if (halt_ok) nstate = DRAIN;
            DRAIN:   if (wake) nstate = RUN;
                     else if (bus.pipe_empty || drain_tmo) nstate = STOPPED;
            STOPPED: if (wake) nstate = WAKE;
            WAKE:    if (res_cnt == 4'(RESUME_CYC - 1)) nstate = RUN;
            default: nstate = RUN;
        endcase
    end

    // Outputs decoded from the next state so they line up with the state they describe.
    always_comb begin
        stop_d     = (nstate == STOPPED);
        resume_n_d = (nstate != WAKE);
        halted_d   = (nstate == STOPPED) | (nstate == WAKE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.stop     <= 1'b0;
            bus.resume_n <= 1'b1;
            bus.halted   <= 1'b0;
            bus.drain_to <= 1'b0;
            bus.stop_cnt <= '0;
        end else begin
            bus.stop     <= stop_d;
            bus.resume_n <= resume_n_d;
            bus.halted   <= halted_d;
            bus.drain_to <= drain_tmo;
            if (halt_ok)
                bus.stop_cnt <= '0;
            else if (state == STOPPED && bus.stop_cnt != {CNT_W{1'b1}})
                bus.stop_cnt <= bus.stop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_clk_halt_ctrl.sv
// Bench for clk_halt_ctrl: two instances (16-bit and 4-bit stop_cnt) share
// stimulus; a timestamp-based phase model is compared every cycle.
module tb_clk_halt_ctrl;
    localparam int DRAIN_MAX  = 16;
    localparam int RESUME_CYC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halt_req = 0, pipe_empty = 0, intr = 0, intr_en = 0, nmi = 0, dbg_resume = 0;

    always #5 clk = ~clk;

    clk_halt_if #(.CNT_W(16)) b16 ();
    clk_halt_if #(.CNT_W(4))  b4 ();

    assign b16.halt_req = halt_req;  assign b4.halt_req = halt_req;
    assign b16.pipe_empty = pipe_empty; assign b4.pipe_empty = pipe_empty;
    assign b16.intr = intr;          assign b4.intr = intr;
    assign b16.intr_en = intr_en;    assign b4.intr_en = intr_en;
    assign b16.nmi = nmi;            assign b4.nmi = nmi;
    assign b16.dbg_resume = dbg_resume; assign b4.dbg_resume = dbg_resume;

    clk_halt_ctrl #(.DRAIN_MAX(DRAIN_MAX), .RESUME_CYC(RESUME_CYC), .CNT_W(16))
        u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    clk_halt_ctrl #(.DRAIN_MAX(DRAIN_MAX), .RESUME_CYC(RESUME_CYC), .CNT_W(4))
        u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase plus entry timestamps; stopped cycles kept unsaturated.
    localparam int P_RUN = 0, P_DRAIN = 1, P_STOP = 2, P_WAKE = 3;
    int m_ph = P_RUN;
    int m_t0 = 0;
    int m_cyc = 0;
    int m_stopped = 0;
    bit m_to = 0;
    bit chk_en = 0;

    always @(posedge clk) begin
        bit w;
        w = nmi | (intr & intr_en) | dbg_resume;
        m_cyc <= m_cyc + 1;
        m_to  <= 1'b0;
        if (!rst_n) begin
            m_ph <= P_RUN;
            m_stopped <= 0;
        end else begin
            case (m_ph)
                P_RUN: if (halt_req && !w) begin
                    m_ph <= P_DRAIN; m_t0 <= m_cyc; m_stopped <= 0;
                end
                P_DRAIN: begin
                    if (w) m_ph <= P_RUN;
                    else if (pipe_empty) m_ph <= P_STOP;
                    else if (m_cyc - m_t0 == DRAIN_MAX) begin
                        m_ph <= P_STOP; m_to <= 1'b1;
                    end
                end
                P_STOP: begin
                    m_stopped <= m_stopped + 1;
                    if (w) begin m_ph <= P_WAKE; m_t0 <= m_cyc; end
                end
                default: if (m_cyc - m_t0 == RESUME_CYC) m_ph <= P_RUN;
            endcase
        end
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stop",     int'(b16.stop),     int'(m_ph == P_STOP));
            chk("resume_n", int'(b16.resume_n), int'(m_ph != P_WAKE));
            chk("halted",   int'(b16.halted),   int'(m_ph == P_STOP || m_ph == P_WAKE));
            chk("drain_to", int'(b16.drain_to), int'(m_to));
            chk("stop_cnt16", int'(b16.stop_cnt), sat(m_stopped, 16));
            chk("stop_cnt4",  int'(b4.stop_cnt),  sat(m_stopped, 4));
            chk("stop4",      int'(b4.stop),      int'(m_ph == P_STOP));
            chk("inv_stop_resume", int'(b16.stop & ~b16.resume_n), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // halt_req pulse in the current cycle; returns one edge later.
    task automatic halt_pulse();
        halt_req = 1; tick(1); halt_req = 0;
    endtask

    initial begin
        tick(1);
        chk_en = 1;
        tick(1);
        chk("rst_stop", int'(b16.stop), 0);
        chk("rst_resume_n", int'(b16.resume_n), 1);
        chk("rst_cnt", int'(b16.stop_cnt), 0);
        rst_n = 1;
        tick(2);

        // T1: empty pipe, wake via enabled interrupt at cycle 10
        pipe_empty = 1;
        halt_pulse();                       // now cycle 1
        chk("t1_drain_stop0", int'(b16.stop), 0);
        tick(1);                            // cycle 2
        chk("t1_stop_c2", int'(b16.stop), 1);
        tick(8);                            // cycle 10
        chk("t1_stop_c10", int'(b16.stop), 1);
        intr = 1; intr_en = 1;
        tick(1);                            // cycle 11
        intr = 0;
        chk("t1_resume_n_c11", int'(b16.resume_n), 0);
        chk("t1_cnt", int'(b16.stop_cnt), 9);
        tick(1);                            // cycle 12
        chk("t1_resume_n_c12", int'(b16.resume_n), 0);
        tick(1);                            // cycle 13
        chk("t1_resume_n_c13", int'(b16.resume_n), 1);
        chk("t1_halted_c13", int'(b16.halted), 0);
        intr_en = 0;
        tick(2);

        // T2: pipe never drains, forced stop
        pipe_empty = 0;
        halt_pulse();                       // cycle 1
        tick(15);                           // cycle 16
        chk("t2_to_c16", int'(b16.drain_to), 0);
        chk("t2_stop_c16", int'(b16.stop), 0);
        tick(1);                            // cycle 17
        chk("t2_to_c17", int'(b16.drain_to), 1);
        chk("t2_stop_c17", int'(b16.stop), 1);
        tick(1);
        chk("t2_to_c18", int'(b16.drain_to), 0);
        dbg_resume = 1; tick(1); dbg_resume = 0;
        tick(3);

        // T3: NMI during drain aborts the halt
        halt_pulse();                       // cycle 1
        tick(2);                            // cycle 3
        nmi = 1;
        tick(1);                            // cycle 4
        nmi = 0;
        chk("t3_halted", int'(b16.halted), 0);
        chk("t3_stop", int'(b16.stop), 0);
        tick(2);

        // T4: masked interrupt does not wake; enabling it does; halt+wake dropped
        pipe_empty = 1;
        halt_pulse(); tick(1);              // cycle 2, stopped
        intr = 1;
        tick(5);                            // cycle 7
        chk("t4_masked_halted", int'(b16.stop), 1);
        intr_en = 1;
        tick(1);                            // cycle 8
        chk("t4_wake", int'(b16.resume_n), 0);
        intr = 0; intr_en = 0;
        tick(3);
        chk("t4_cnt_hold", int'(b16.stop_cnt), 6);
        halt_req = 1; nmi = 1;
        tick(1);
        halt_req = 0; nmi = 0;
        chk("t4_drop_halted", int'(b16.halted), 0);
        chk("t4_drop_cnt", int'(b16.stop_cnt), 6);
        tick(2);

        // T5: reset while stopped, then while waking
        halt_pulse(); tick(2);
        rst_n = 0; tick(1); rst_n = 1;
        chk("t5a_stop", int'(b16.stop), 0);
        chk("t5a_halted", int'(b16.halted), 0);
        chk("t5a_cnt", int'(b16.stop_cnt), 0);
        tick(1);
        halt_pulse(); tick(2);
        dbg_resume = 1; tick(1); dbg_resume = 0;
        chk("t5b_in_wake", int'(b16.resume_n), 0);
        rst_n = 0; tick(1); rst_n = 1;
        chk("t5b_resume_n", int'(b16.resume_n), 1);
        chk("t5b_halted", int'(b16.halted), 0);
        chk("t5b_cnt", int'(b16.stop_cnt), 0);
        tick(2);

        // T6: 40 stopped cycles; 4-bit counter saturates
        halt_pulse();                       // cycle 1
        tick(40);                           // cycle 41
        nmi = 1; tick(1); nmi = 0;          // cycle 42
        chk("t6_cnt16", int'(b16.stop_cnt), 40);
        chk("t6_cnt4", int'(b4.stop_cnt), 15);
        tick(4);
        chk("t6_cnt4_hold", int'(b4.stop_cnt), 15);
        chk("t6_run", int'(b16.halted), 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
